mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
Parametrised memory stage for the pipelined processor. It replaces the fixed 64-bit, single-cycle MEM stage with one that has configurable data-memory depth and access latency, byte/half/word/doubleword loads and stores with sign or zero extension, and misalignment detection. It also adds a stall handshake to upstream stages, CBZ/CBNZ branch resolution, and a MEM/WB register with valid tracking and bubble insertion. It sits between EX/MEM and the writeback stage.

Parameters:
DEPTH, 128, number of 64-bit words in the internal data memory (power of 2, at least 2)
MEM_LAT, 2, cycles per memory access (at least 1)
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
resetl  in  1  reset; asynchronous, active-low
valid_MEM  in  1  an instruction is present in MEM
RegWrite_MEM, Mem2Reg_MEM, MemRead_MEM, MemWrite_MEM  in  1 each  control signals from EX/MEM
Branch_MEM, BranchNZ_MEM, Uncondbranch_MEM  in  1 each  branch controls
ALUzero_MEM  in  1  ALU result equals zero
MemSize_MEM  in  2  access size: 0=byte, 1=half, 2=word, 3=doubleword
MemSigned_MEM  in  1  load sign-extends when 1
RD_MEM  in  RD_W  destination register
RegOutB_MEM, ALUout_MEM, PCtarget_MEM  in  64 each  store data, address, branch target
stall  out  1  hold upstream stages; inputs must stay stable while this is high
PCSrc  out  1  take branch
PCtarget  out  64  branch target, passed through from PCtarget_MEM
valid_WB, RegWrite_WB, Mem2Reg_WB, misalign_WB  out  1 each  registered flags to WB
RD_WB  out  RD_W  registered destination
ALUout_WB, ReadData_WB  out  64 each  registered ALU result and load data

Behaviour:
- Addressing: byte address A = ALUout_MEM, little-endian.
  - Word index = A[log2(DEPTH)+2:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8.
  - Byte offset = A[2:0].
- Definitions:
  - memop = valid_MEM & (MemRead_MEM | MemWrite_MEM).
  - misalign = memop & (offset is not a multiple of 2^MemSize_MEM).
- Misaligned access:
  - Memory is not accessed and no stall is raised.
  - Registered result: ReadData_WB=0, misalign_WB=1, RegWrite_WB=0.
- Access FSM, two states:
  - IDLE, with counter cnt=0.
  - BUSY, in which cnt increments every cycle.
  - An aligned memop completes when cnt==MEM_LAT-1. With MEM_LAT=1 it completes in IDLE in the same cycle.
  - IDLE goes to BUSY on an aligned memop that is not yet complete.
  - BUSY returns to IDLE with cnt=0 on completion.
- stall = aligned memop & !complete, combinational. An access therefore stalls for exactly MEM_LAT-1 cycles.
- Store: on the completion edge only (exactly once), write the low 2^MemSize bytes of RegOutB_MEM into the addressed byte lanes. All other lanes are unchanged.
- Load: on the completion cycle, extract 2^MemSize bytes from the addressed lanes. Sign-extend to 64 bits if MemSigned_MEM, otherwise zero-extend.
- If MemRead and MemWrite are both set, the write is performed and ReadData_WB returns the old data.
- PCSrc is combinational:
  - PCSrc = valid_MEM & (Uncondbranch_MEM | (Branch_MEM & (ALUzero_MEM ^ BranchNZ_MEM))).
  - Branches never stall.
- MEM/WB register, updated on the posedge:
  - When stall=0: capture RD, ALUout, Mem2Reg, load data, and misalign. valid_WB=valid_MEM. RegWrite_WB=RegWrite_MEM & valid_MEM & !misalign.
  - When stall=1: insert a bubble. valid_WB=0 and RegWrite_WB=0; the other fields hold.
- Reset (resetl low, asynchronous, including mid-access):
  - All WB outputs go to 0, FSM returns to IDLE, cnt=0.
  - A pending store is aborted and nothing is written.
  - Memory contents are not reset.

Test Plan:
- MEM_LAT=2. Store dword 0x1122334455667788 at 0x10, then load dword from 0x10 -> stall is high for exactly 1 cycle on each access; ReadData_WB=0x1122334455667788 with valid_WB=1. The bubble cycle shows valid_WB=0.
- Store byte 0xAB at 0x13, then three loads -> signed byte load from 0x13 gives 0xFFFFFFFFFFFFFFAB; unsigned gives 0x00000000000000AB; dword load from 0x10 gives 0x11223344AB667788.
- Half load from 0x11 -> misalign_WB=1, RegWrite_WB=0, ReadData_WB=0, stall stays 0. Word store to 0x12 -> memory unchanged, confirmed by a later dword read of 0x10.
- Branch_MEM=1, ALUzero=1, BranchNZ=0 -> PCSrc=1 and PCtarget equals PCtarget_MEM. Same with BranchNZ=1 -> PCSrc=0. Uncondbranch=1 -> PCSrc=1. Any case with valid_MEM=0 -> PCSrc=0.
- Pulse resetl low during the stall cycle of a dword store of 0xDEAD to 0x20 (prior content 0x5) -> outputs clear immediately, FSM returns to IDLE, and a later load from 0x20 returns 0x5.
- DEPTH=128: store 0x77 as a dword to 0x400, then load from 0x0 -> 0x77 (address wrap-around).

Source files
------------

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage with multi-cycle data memory, sized/extended loads
// and stores, misalignment trap, CBZ/CBNZ resolution and a MEM/WB register.
module mem_stage_pipe #(
  parameter int DEPTH   = 128,
  parameter int MEM_LAT = 2,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            resetl,
  input  logic            valid_MEM,
  input  logic            RegWrite_MEM,
  input  logic            Mem2Reg_MEM,
  input  logic            MemRead_MEM,
  input  logic            MemWrite_MEM,
  input  logic            Branch_MEM,
  input  logic            BranchNZ_MEM,
  input  logic            Uncondbranch_MEM,
  input  logic            ALUzero_MEM,
  input  logic [1:0]      MemSize_MEM,
  input  logic            MemSigned_MEM,
  input  logic [RD_W-1:0] RD_MEM,
  input  logic [63:0]     RegOutB_MEM,
  input  logic [63:0]     ALUout_MEM,
  input  logic [63:0]     PCtarget_MEM,
  output logic            stall,
  output logic            PCSrc,
  output logic [63:0]     PCtarget,
  output logic            valid_WB,
  output logic            RegWrite_WB,
  output logic            Mem2Reg_WB,
  output logic            misalign_WB,
  output logic [RD_W-1:0] RD_WB,
  output logic [63:0]     ALUout_WB,
  output logic [63:0]     ReadData_WB
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [2:0] off, amask;
  logic [5:0] sh;
  logic memop, mis, amemop, done;
  logic [63:0] word, rsh, bmask, wmask, ldata;
  assign idx   = ALUout_MEM[AW+2:3];
  assign off   = ALUout_MEM[2:0];
  assign sh    = {off, 3'b000};
  assign amask = (3'd1 << MemSize_MEM) - 3'd1;
  assign memop = valid_MEM & (MemRead_MEM | MemWrite_MEM);
  assign mis   = memop & |(off & amask);
  assign amemop = memop & ~mis;
  assign PCtarget = PCtarget_MEM;
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = stall ? BUSY : IDLE;
    cnt_n   = stall ? cnt + 1'b1 : '0;
  end
  // In IDLE the counter is always zero, so only a single-cycle memory completes there
  always_comb begin
    done  = amemop & (state == BUSY ? cnt == CW'(MEM_LAT - 1) : MEM_LAT == 1);
    stall = amemop & ~done;
    PCSrc = valid_MEM & (Uncondbranch_MEM | (Branch_MEM & (ALUzero_MEM ^ BranchNZ_MEM)));
  end
  always_comb begin
    word  = mem[idx];
    rsh   = word >> sh;
    bmask = MemSize_MEM == 2'd3 ? '1 : (64'd1 << (7'd8 << MemSize_MEM)) - 64'd1;
    wmask = bmask << sh;
    ldata = MemSize_MEM == 2'd0 ? {{56{MemSigned_MEM & rsh[7]}},  rsh[7:0]}  :
            MemSize_MEM == 2'd1 ? {{48{MemSigned_MEM & rsh[15]}}, rsh[15:0]} :
            MemSize_MEM == 2'd2 ? {{32{MemSigned_MEM & rsh[31]}}, rsh[31:0]} : rsh;
  end
  always_ff @(posedge clk)
    if (done && MemWrite_MEM) mem[idx] <= (word & ~wmask) | ((RegOutB_MEM << sh) & wmask);
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) begin
      valid_WB    <= 1'b0;
      RegWrite_WB <= 1'b0;
      Mem2Reg_WB  <= 1'b0;
      misalign_WB <= 1'b0;
      RD_WB       <= '0;
      ALUout_WB   <= '0;
      ReadData_WB <= '0;
    end else if (stall) begin
      valid_WB    <= 1'b0;
      RegWrite_WB <= 1'b0;
    end else begin
      valid_WB    <= valid_MEM;
      RegWrite_WB <= RegWrite_MEM & valid_MEM & ~mis;
      Mem2Reg_WB  <= Mem2Reg_MEM;
      misalign_WB <= mis;
      RD_WB       <= RD_MEM;
      ALUout_WB   <= ALUout_MEM;
      ReadData_WB <= (amemop & MemRead_MEM) ? ldata : '0;
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: scoreboard bench for mem_stage_pipe with a byte-array memory model.
module tb_mem_stage_pipe;
  localparam int DEPTH = 128, MEM_LAT = 2, RD_W = 5;
  localparam int AB = $clog2(DEPTH) + 3;
  logic clk = 0, resetl = 1;
  logic valid_MEM = 0, RegWrite_MEM = 0, Mem2Reg_MEM = 0, MemRead_MEM = 0, MemWrite_MEM = 0;
  logic Branch_MEM = 0, BranchNZ_MEM = 0, Uncondbranch_MEM = 0, ALUzero_MEM = 0, MemSigned_MEM = 0;
  logic [1:0] MemSize_MEM = 0;
  logic [RD_W-1:0] RD_MEM = 0;
  logic [63:0] RegOutB_MEM = 0, ALUout_MEM = 0, PCtarget_MEM = 0;
  logic stall, PCSrc, valid_WB, RegWrite_WB, Mem2Reg_WB, misalign_WB;
  logic [63:0] PCtarget, ALUout_WB, ReadData_WB;
  logic [RD_W-1:0] RD_WB;
  typedef struct {logic rw, mis; logic [63:0] rdata, alu; logic [RD_W-1:0] rd;} exp_t;
  exp_t q[$];
  logic [7:0] mdl [DEPTH*8];
  int checks = 0, fails = 0;

  mem_stage_pipe #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RD_W(RD_W)) dut (
    .clk(clk), .resetl(resetl), .valid_MEM(valid_MEM), .RegWrite_MEM(RegWrite_MEM),
    .Mem2Reg_MEM(Mem2Reg_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .Branch_MEM(Branch_MEM), .BranchNZ_MEM(BranchNZ_MEM), .Uncondbranch_MEM(Uncondbranch_MEM),
    .ALUzero_MEM(ALUzero_MEM), .MemSize_MEM(MemSize_MEM), .MemSigned_MEM(MemSigned_MEM),
    .RD_MEM(RD_MEM), .RegOutB_MEM(RegOutB_MEM), .ALUout_MEM(ALUout_MEM), .PCtarget_MEM(PCtarget_MEM),
    .stall(stall), .PCSrc(PCSrc), .PCtarget(PCtarget), .valid_WB(valid_WB), .RegWrite_WB(RegWrite_WB),
    .Mem2Reg_WB(Mem2Reg_WB), .misalign_WB(misalign_WB), .RD_WB(RD_WB), .ALUout_WB(ALUout_WB),
    .ReadData_WB(ReadData_WB)
  );

  always #5 clk = ~clk;

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [63:0] addr, input logic [63:0] data, input logic [RD_W-1:0] rdi);
    exp_t e, g;
    int n, nb, st;
    logic [AB-1:0] a;
    a = addr[AB-1:0];
    nb = 1 << sz;
    e.mis = (a % nb) != 0;
    e.rw = ~e.mis;
    e.alu = addr;
    e.rd = rdi;
    e.rdata = '0;
    if (rd && !e.mis) begin
      for (int i = 0; i < nb; i++) e.rdata |= 64'(mdl[int'(a) + i]) << (8 * i);
      if (sg && nb < 8 && e.rdata[8*nb-1]) e.rdata |= ~64'd0 << (8 * nb);
    end
    if (wr && !e.mis) for (int i = 0; i < nb; i++) mdl[int'(a) + i] = data[8*i +: 8];
    q.push_back(e);
    @(negedge clk);
    valid_MEM = 1; RegWrite_MEM = 1; Mem2Reg_MEM = rd; MemRead_MEM = rd; MemWrite_MEM = wr;
    Branch_MEM = 0; BranchNZ_MEM = 0; Uncondbranch_MEM = 0; ALUzero_MEM = 0;
    MemSize_MEM = sz; MemSigned_MEM = sg; RD_MEM = rdi; RegOutB_MEM = data; ALUout_MEM = addr;
    #1;
    n = 0;
    while (stall && n < 10) begin
      n++;
      @(posedge clk); #1;
      checks++;
      if (valid_WB !== 1'b0 || RegWrite_WB !== 1'b0) begin
        fails++;
        $display("FAIL bubble addr=%h: valid_WB=%b RegWrite_WB=%b, required 0/0", addr, valid_WB, RegWrite_WB);
      end
    end
    st = e.mis ? 0 : MEM_LAT - 1;
    checks++;
    if (n !== st) begin
      fails++;
      $display("FAIL stall_cycles addr=%h: got %0d, required %0d", addr, n, st);
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty addr=%h: got 0 entries, required 1", addr);
    end else begin
      g = q.pop_front();
      if (valid_WB !== 1'b1 || RegWrite_WB !== g.rw || misalign_WB !== g.mis || Mem2Reg_WB !== rd ||
          ReadData_WB !== g.rdata || ALUout_WB !== g.alu || RD_WB !== g.rd) begin
        fails++;
        $display("FAIL wb addr=%h: v=%b rw=%b mis=%b m2r=%b rd=%0d alu=%h data=%h, required v=1 rw=%b mis=%b m2r=%b rd=%0d alu=%h data=%h",
                 addr, valid_WB, RegWrite_WB, misalign_WB, Mem2Reg_WB, RD_WB, ALUout_WB, ReadData_WB,
                 g.rw, g.mis, rd, g.rd, g.alu, g.rdata);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0; Branch_MEM = 0; Uncondbranch_MEM = 0;
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (valid_WB !== 0 || RegWrite_WB !== 0 || Mem2Reg_WB !== 0 || misalign_WB !== 0 ||
        RD_WB !== 0 || ALUout_WB !== 0 || ReadData_WB !== 0) begin
      fails++;
      $display("FAIL %s: v=%b rw=%b m2r=%b mis=%b rd=%0d alu=%h data=%h, required all 0",
               tag, valid_WB, RegWrite_WB, Mem2Reg_WB, misalign_WB, RD_WB, ALUout_WB, ReadData_WB);
    end
  endtask

  task automatic test_reset();
    #3 resetl = 0;
    #1 check_cleared("reset_state");
    checks++;
    if (stall !== 0 || PCSrc !== 0) begin
      fails++;
      $display("FAIL reset_comb: stall=%b PCSrc=%b, required 0/0", stall, PCSrc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) resetl = 1;
  endtask

  task automatic test_dword();
    op(0, 1, 3, 0, 64'h10, 64'h1122334455667788, 5'd1);
    op(1, 0, 3, 0, 64'h10, 64'h0, 5'd2);
  endtask

  task automatic test_byte();
    op(0, 1, 0, 0, 64'h13, 64'h00000000000000AB, 5'd3);
    op(1, 0, 0, 1, 64'h13, 64'h0, 5'd4);
    op(1, 0, 0, 0, 64'h13, 64'h0, 5'd5);
    op(1, 0, 3, 0, 64'h10, 64'h0, 5'd6);
    op(0, 1, 1, 0, 64'h16, 64'h000000000000C3D4, 5'd7);
    op(1, 0, 1, 1, 64'h16, 64'h0, 5'd8);
    op(0, 1, 2, 0, 64'h18, 64'h0000000087654321, 5'd9);
    op(1, 0, 2, 1, 64'h18, 64'h0, 5'd10);
    op(1, 0, 2, 0, 64'h18, 64'h0, 5'd11);
  endtask

  task automatic test_misalign();
    op(1, 0, 1, 0, 64'h11, 64'h0, 5'd12);
    op(0, 1, 2, 0, 64'h12, 64'hFFFFFFFFFFFFFFFF, 5'd13);
    op(0, 1, 3, 0, 64'h14, 64'hFFFFFFFFFFFFFFFF, 5'd14);
    op(1, 0, 3, 0, 64'h10, 64'h0, 5'd15);
  endtask

  task automatic test_branch();
    logic [5:0] br [7];
    logic [63:0] t;
    br = '{6'b110101, 6'b111100, 6'b100011, 6'b000010, 6'b010100, 6'b111001, 6'b110000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      t = {$urandom, $urandom};
      {valid_MEM, Branch_MEM, BranchNZ_MEM, ALUzero_MEM, Uncondbranch_MEM} = br[i][5:1];
      MemRead_MEM = 0; MemWrite_MEM = 0; PCtarget_MEM = t;
      #1;
      checks++;
      if (PCSrc !== br[i][0] || PCtarget !== t || stall !== 0) begin
        fails++;
        $display("FAIL branch row %0d: PCSrc=%b PCtarget=%h stall=%b, required %b %h 0",
                 i, PCSrc, PCtarget, stall, br[i][0], t);
      end
    end
    idle();
  endtask

  task automatic test_reset_midstore();
    op(0, 1, 3, 0, 64'h20, 64'h5, 5'd16);
    @(negedge clk);
    valid_MEM = 1; MemWrite_MEM = 1; MemRead_MEM = 0; MemSize_MEM = 3;
    ALUout_MEM = 64'h20; RegOutB_MEM = 64'hDEAD;
    #1;
    checks++;
    if (stall !== 1) begin
      fails++;
      $display("FAIL midstore_stall: stall=%b, required 1", stall);
    end
    #1 resetl = 0;
    #1 check_cleared("midstore_reset");
    idle();
    @(negedge clk) resetl = 1;
    op(1, 0, 3, 0, 64'h20, 64'h0, 5'd17);
  endtask

  task automatic test_wrap();
    op(0, 1, 3, 0, 64'h400, 64'h77, 5'd18);
    op(1, 0, 3, 0, 64'h0, 64'h0, 5'd19);
  endtask

  task automatic test_back_to_back();
    op(1, 1, 3, 0, 64'h10, 64'hCAFEF00D12345678, 5'd20);
    op(1, 0, 3, 0, 64'h10, 64'h0, 5'd21);
    idle();
    @(posedge clk); #1;
    checks++;
    if (valid_WB !== 0 || RegWrite_WB !== 0) begin
      fails++;
      $display("FAIL idle_wb: valid_WB=%b RegWrite_WB=%b, required 0/0", valid_WB, RegWrite_WB);
    end
  endtask

  initial begin
    test_reset();
    test_dword();
    test_byte();
    test_misalign();
    test_branch();
    test_reset_midstore();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
